xgmii_rx_fifo_reader: RTL and testbench
=======================================

Name: xgmii_rx_fifo_reader

Overview:
Downstream stage of the XGMII RX engine. Drains the 72-bit XGMII-RX FWFT FIFO, which holds one IPNUMA write command per packet. Parses each command's header and address entries, then issues one memory-write request plus its 64-bit data beats to the PCIe TX request builder over valid/ready handshakes. Malformed packets are dropped and counted.

Parameters:
MAX_DW, 32, largest accepted payload in dwords; length field 0 encodes 1024.
CNT_W, 16, width of pkt_count.

Ports:
clk  in  1  design clock; all logic on its rising edge
sys_rst  in  1  synchronous, active-high reset
fifo_dout  in  72  FIFO head entry: [71]=SOF, [70]=EOF, [69:64] reserved, [63:0] data
fifo_empty  in  1  FIFO empty
fifo_rd_en  out  1  pop head entry (combinational)
req_valid  out  1  request header valid
req_ready  in  1  builder accepts header
req_addr  out  64  target byte address; [63:32]=0 when req_64=0
req_len  out  10  payload length in dwords (0 = 1024)
req_64  out  1  64-bit addressing
dat_valid  out  1  data beat valid
dat_ready  in  1  builder accepts beat
dat  out  64  data; low dword = first dword
dat_be  out  8  byte enables
dat_last  out  1  final beat of request
pkt_count  out  CNT_W  requests fully delivered
err_count  out  8  packets dropped, saturating at 8'hff

Behaviour:
- Reset, synchronous and active-high: state=IDLE. req_valid, dat_valid, dat_last, pkt_count, err_count all 0. req_addr, req_len, req_64, dat, dat_be all 0. fifo_rd_en is 0 while sys_rst=1.
- Reset mid-packet abandons the packet. Entries left in the FIFO are later flushed through the IDLE discard rule.
- Command entry (SOF=1): bit64=data[29], len=data[9:0]. Effective dword count: eff = (len==0) ? 1024 : len. Beat count: beats = ceil(eff/2).
- Address entry: data[63:0]. Bits [1:0] are ignored and forced to 0. When bit64=0, req_addr[63:32] is forced to 0.
- IDLE:
  - If not empty and SOF=1: pop the entry, latch the command; go to ADDR if eff<=MAX_DW, else go to DRAIN.
  - If not empty and SOF=0: pop and discard the entry; err_count is not incremented.
  - If an entry has SOF=1 and EOF=1: drop it, err+1, stay in IDLE.
- ADDR:
  - If not empty: pop the entry.
  - If EOF=1 on this entry: err+1, go to IDLE.
  - Otherwise: load req_addr, req_len, req_64; req_valid<=1; go to REQ.
- REQ: hold all req_* signals stable until req_valid&&req_ready. On that cycle: req_valid<=0, beat counter <= beats, go to DATA. No FIFO reads occur in REQ.
- DATA:
  - fifo_rd_en = !fifo_empty && (!dat_valid || dat_ready) && remaining>0.
  - On a pop: dat<=data, dat_valid<=1, remaining decrements.
  - dat_last=1 on the beat where remaining goes 1->0.
  - dat_be: 8'hff, except on the last beat when eff is odd, where it is 8'h0f.
  - If the output beat is taken (dat_ready) and no new pop occurs in the same cycle: dat_valid<=0.
  - Accept and pop may occur in the same cycle, giving 1 beat/cycle sustained.
  - Early EOF (EOF=1 on a beat that is not the last): that beat is still presented with dat_last=1, err+1, go to IDLE. The builder must tolerate a short request.
  - Normal end: when the last beat is accepted, pkt_count+1 (wraps). Go to IDLE if that beat carried EOF=1, else go to DRAIN.
- DRAIN: pop every non-empty entry until one with EOF=1 is popped, then go to IDLE.
  - An oversize packet arriving through DRAIN increments err once, at entry to DRAIN.
  - Surplus entries after the last data beat are discarded and do not increment err.
- SOF=1 seen in ADDR, DATA or DRAIN: treated as the end of the current packet. Do not pop it; err+1 unless in DRAIN; go to IDLE, which then re-parses that entry.
- Simultaneous err and pkt increments cannot occur. err_count saturates at 8'hff.
- Latency: from FIFO non-empty with the command entry to req_valid is 2 cycles, with no FIFO stalls.

Test Plan:
- Command len=4, bit64=0; address 0x0000_0001_2345_6789; two data entries, EOF on the 2nd -> req_addr=0x2345_6788, req_len=4, req_64=0. Two beats, both dat_be=ff, last beat dat_last=1. pkt_count=1, err_count=0.
- len=3, bit64=1, address 0x1_0000_1000, two data entries -> req_addr=0x1_0000_1000, req_64=1. Beat 2 has dat_be=0f and dat_last=1.
- len=4, EOF on the 1st data entry -> one beat with dat_last=1; err_count=1, pkt_count=0. The next valid packet is processed normally.
- len=0 with MAX_DW=32, followed by 5 entries, EOF on the last -> no req_valid, all 6 entries popped, err_count=1, state returns to IDLE.
- len=8 with dat_ready toggling 1,0,0,1,... and req_ready delayed 5 cycles -> req_* and dat/dat_be held stable while stalled, exactly 4 beats delivered in order, no FIFO pops during REQ.
- sys_rst asserted mid-DATA, remaining entries left in the FIFO, then a new SOF packet -> all outputs 0 during reset; leftover entries discarded without err; the new packet is delivered correctly.

Source files
------------

// File: rtl/xgmii_rx_fifo_reader.sv
// rtl/xgmii_rx_fifo_reader.sv - drains XGMII-RX command FIFO into memory-write requests plus data beats
module xgmii_rx_fifo_reader #(
    parameter int MAX_DW = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic [71:0]      fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [63:0]      req_addr,
    output logic [9:0]       req_len,
    output logic             req_64,
    output logic             dat_valid,
    input  logic             dat_ready,
    output logic [63:0]      dat,
    output logic [7:0]       dat_be,
    output logic             dat_last,
    output logic [CNT_W-1:0] pkt_count,
    output logic [7:0]       err_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_REQ   = 3'd2,
        S_DATA  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // Payload limit clamped to the largest encodable length.
    localparam logic [10:0] MAX_EFF = (MAX_DW >= 1024) ? 11'd1024 : 11'(MAX_DW);

    state_t state;
    state_t state_nxt;

    // FIFO head decode
    logic        head_sof;
    logic        head_eof;
    logic [63:0] head_data;

    assign head_sof  = fifo_dout[71];
    assign head_eof  = fifo_dout[70];
    assign head_data = fifo_dout[63:0];

    // Command decode of the head entry; only meaningful when it carries SOF.
    logic [10:0] cmd_eff;
    logic        cmd_fits;
    logic [9:0]  cmd_beats;

    assign cmd_eff   = (head_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, head_data[9:0]};
    assign cmd_fits  = (cmd_eff <= MAX_EFF);
    assign cmd_beats = 10'((cmd_eff + 11'd1) >> 1);

    // Latched command fields
    logic       cmd_64;
    logic [9:0] cmd_len;
    logic       cmd_odd;
    logic [9:0] cmd_nbeats;
    logic [9:0] remaining;
    logic       last_eof;

    // Control strobes
    logic beat_slot;
    logic last_pop;
    logic latch_cmd;
    logic load_addr;
    logic req_done;
    logic beat_pop;
    logic pkt_inc;
    logic err_inc;

    // A new data beat may be fetched when the output register is free or being emptied.
    assign beat_slot = !fifo_empty && (!dat_valid || dat_ready) && (remaining != 10'd0);
    assign last_pop  = (remaining == 10'd1);

    // State register
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (latch_cmd) begin
                    state_nxt = cmd_fits ? S_ADDR : S_DRAIN;
                end
            end
            S_ADDR: begin
                if (!fifo_empty) begin
                    state_nxt = (head_sof || head_eof) ? S_IDLE : S_REQ;
                end
            end
            S_REQ: begin
                if (req_done) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (beat_slot && head_sof) begin
                    state_nxt = S_IDLE;
                end else if (beat_pop && head_eof && !last_pop) begin
                    state_nxt = S_IDLE;
                end else if (pkt_inc) begin
                    state_nxt = last_eof ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!fifo_empty && (head_sof || head_eof)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output/strobe logic: FIFO pop and datapath enables per state
    always_comb begin
        fifo_rd_en = 1'b0;
        latch_cmd  = 1'b0;
        load_addr  = 1'b0;
        req_done   = 1'b0;
        beat_pop   = 1'b0;
        pkt_inc    = 1'b0;
        err_inc    = 1'b0;
        if (!sys_rst) begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        if (head_sof) begin
                            if (head_eof) begin
                                err_inc = 1'b1;
                            end else begin
                                latch_cmd = 1'b1;
                                err_inc   = !cmd_fits;
                            end
                        end
                    end
                end
                S_ADDR: begin
                    if (!fifo_empty) begin
                        if (head_sof) begin
                            // Next packet has started: leave it for IDLE to parse.
                            err_inc = 1'b1;
                        end else begin
                            fifo_rd_en = 1'b1;
                            if (head_eof) begin
                                err_inc = 1'b1;
                            end else begin
                                load_addr = 1'b1;
                            end
                        end
                    end
                end
                S_REQ: begin
                    req_done = req_valid && req_ready;
                end
                S_DATA: begin
                    if (beat_slot) begin
                        if (head_sof) begin
                            err_inc = 1'b1;
                        end else begin
                            fifo_rd_en = 1'b1;
                            beat_pop   = 1'b1;
                            err_inc    = head_eof && !last_pop;
                        end
                    end
                    if ((remaining == 10'd0) && dat_valid && dat_ready) begin
                        pkt_inc = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!fifo_empty && !head_sof) begin
                        fifo_rd_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Command latch, request register, beat register and counters
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            cmd_64     <= 1'b0;
            cmd_len    <= 10'd0;
            cmd_odd    <= 1'b0;
            cmd_nbeats <= 10'd0;
            remaining  <= 10'd0;
            last_eof   <= 1'b0;
            req_valid  <= 1'b0;
            req_addr   <= 64'd0;
            req_len    <= 10'd0;
            req_64     <= 1'b0;
            dat_valid  <= 1'b0;
            dat        <= 64'd0;
            dat_be     <= 8'd0;
            dat_last   <= 1'b0;
            pkt_count  <= '0;
            err_count  <= 8'd0;
        end else begin
            if (latch_cmd) begin
                cmd_64     <= head_data[29];
                cmd_len    <= head_data[9:0];
                cmd_odd    <= cmd_eff[0];
                cmd_nbeats <= cmd_beats;
            end

            if (load_addr) begin
                req_addr  <= cmd_64 ? {head_data[63:2], 2'b00}
                                    : {32'd0, head_data[31:2], 2'b00};
                req_len   <= cmd_len;
                req_64    <= cmd_64;
                req_valid <= 1'b1;
            end else if (req_done) begin
                req_valid <= 1'b0;
                remaining <= cmd_nbeats;
            end

            if (beat_pop) begin
                dat       <= head_data;
                dat_valid <= 1'b1;
                dat_last  <= last_pop || head_eof;
                dat_be    <= (last_pop && cmd_odd) ? 8'h0f : 8'hff;
                last_eof  <= head_eof;
                remaining <= remaining - 10'd1;
            end else if (dat_valid && dat_ready) begin
                dat_valid <= 1'b0;
                dat_last  <= 1'b0;
            end

            if (pkt_inc) begin
                pkt_count <= pkt_count + 1'b1;
            end

            if (err_inc && (err_count != 8'hff)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_xgmii_rx_fifo_reader.sv
// tb/tb_xgmii_rx_fifo_reader.sv - self-checking bench for xgmii_rx_fifo_reader
module tb_xgmii_rx_fifo_reader;

    localparam int CNT_W = 16;
    localparam int K_PKT = 0;
    localparam int K_SOFEOF = 1;
    localparam int K_STRAY = 2;
    localparam int K_ADDR_EOF = 3;
    localparam int NV = 13;

    typedef struct packed {
        logic [63:0] addr;
        logic [9:0]  len;
        logic        b64;
    } req_t;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  be;
        logic        last;
    } beat_t;

    typedef struct {
        int          kind;
        int          len;
        bit          b64;
        logic [63:0] addr;
        int          nd;
        int          rmode;
        bit          exp_req;
        logic [63:0] exp_addr;
        int          exp_beats;
        logic [7:0]  last_be;
        int          d_pkt;
        int          d_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic [71:0]      fifo_dout = '0;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic             req_valid;
    logic             req_ready = 1'b1;
    logic [63:0]      req_addr;
    logic [9:0]       req_len;
    logic             req_64;
    logic             dat_valid;
    logic             dat_ready = 1'b1;
    logic [63:0]      dat;
    logic [7:0]       dat_be;
    logic             dat_last;
    logic [CNT_W-1:0] pkt_count;
    logic [7:0]       err_count;

    logic [71:0] fq[$];
    req_t        exp_req_q[$];
    beat_t       exp_beat_q[$];
    vec_t        vt[NV];

    int n_checks = 0;
    int n_fail = 0;
    int n_pops = 0;
    int rmode = 0;
    bit sb_on = 1'b1;
    int exp_pkt = 0;
    int exp_err = 0;
    int rv_cnt = 0;
    int ph = 0;

    bit          p_req_stall = 1'b0;
    bit          p_dat_stall = 1'b0;
    logic [63:0] p_req_addr, p_dat;
    logic [9:0]  p_req_len;
    logic        p_req_64, p_dat_last;
    logic [7:0]  p_dat_be;

    xgmii_rx_fifo_reader #(.MAX_DW(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_64(req_64),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat(dat), .dat_be(dat_be),
        .dat_last(dat_last), .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd();
        return {$urandom, $urandom};
    endfunction

    task automatic push(input bit sof, input bit eof, input logic [63:0] d);
        fq.push_back({sof, eof, 6'b0, d});
    endtask

    // FIFO model: pops on the clock edge, head presented from the falling edge
    always @(posedge clk) begin
        logic [71:0] tmp;
        if (fifo_rd_en) begin
            if (fq.size() > 0) begin
                tmp = fq.pop_front();
                n_pops++;
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL fifo_underflow: got pop, expected none");
            end
        end
    end

    always @(negedge clk) begin
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() > 0) ? fq[0] : 72'd0;
    end

    // Downstream ready patterns: 0 always ready, 1 delayed/toggling, 2 random
    always @(posedge clk) begin
        #1;
        if (req_valid) rv_cnt++;
        else rv_cnt = 0;
        case (rmode)
            1: begin
                req_ready = (rv_cnt > 5);
                dat_ready = ((ph % 3) == 0);
                ph++;
            end
            2: begin
                req_ready = $urandom_range(0, 1) == 1;
                dat_ready = $urandom_range(0, 1) == 1;
            end
            default: begin
                req_ready = 1'b1;
                dat_ready = 1'b1;
            end
        endcase
    end

    // Scoreboard monitor, stall stability and no-pop-in-REQ checks
    always @(negedge clk) begin
        req_t  r;
        beat_t b;
        if (sb_on && !sys_rst) begin
            if (req_valid && req_ready) begin
                if (exp_req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_unexpected: got addr 0x%0h, expected no request", req_addr);
                end else begin
                    r = exp_req_q.pop_front();
                    chk("req_addr", req_addr, r.addr);
                    chk("req_len", 64'(req_len), 64'(r.len));
                    chk("req_64", 64'(req_64), 64'(r.b64));
                end
            end
            if (dat_valid && dat_ready) begin
                if (exp_beat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got dat 0x%0h, expected no beat", dat);
                end else begin
                    b = exp_beat_q.pop_front();
                    chk("dat", dat, b.d);
                    chk("dat_be", 64'(dat_be), 64'(b.be));
                    chk("dat_last", 64'(dat_last), 64'(b.last));
                end
            end
            if (req_valid) chk("no_pop_in_req", 64'(fifo_rd_en), 64'd0);
            if (p_req_stall) begin
                chk("req_hold_valid", 64'(req_valid), 64'd1);
                chk("req_hold_addr", req_addr, p_req_addr);
                chk("req_hold_len", 64'(req_len), 64'(p_req_len));
                chk("req_hold_64", 64'(req_64), 64'(p_req_64));
            end
            if (p_dat_stall) begin
                chk("dat_hold_valid", 64'(dat_valid), 64'd1);
                chk("dat_hold_data", dat, p_dat);
                chk("dat_hold_be", 64'(dat_be), 64'(p_dat_be));
                chk("dat_hold_last", 64'(dat_last), 64'(p_dat_last));
            end
        end
        p_req_stall = req_valid && !req_ready;
        p_dat_stall = dat_valid && !dat_ready;
        p_req_addr  = req_addr;
        p_req_len   = req_len;
        p_req_64    = req_64;
        p_dat       = dat;
        p_dat_be    = dat_be;
        p_dat_last  = dat_last;
    end

    task automatic check_reset_zero(input string tag);
        chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
        chk({tag, "_dat_valid"}, 64'(dat_valid), 64'd0);
        chk({tag, "_dat_last"}, 64'(dat_last), 64'd0);
        chk({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
        chk({tag, "_err_count"}, 64'(err_count), 64'd0);
        chk({tag, "_req_addr"}, req_addr, 64'd0);
        chk({tag, "_req_len"}, 64'(req_len), 64'd0);
        chk({tag, "_req_64"}, 64'(req_64), 64'd0);
        chk({tag, "_dat"}, dat, 64'd0);
        chk({tag, "_dat_be"}, 64'(dat_be), 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while ((fq.size() != 0 || exp_req_q.size() != 0 || exp_beat_q.size() != 0 ||
                req_valid || dat_valid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_completes"}, 64'(cyc < 3000), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic add_err(input int d);
        exp_err = (exp_err + d > 255) ? 255 : exp_err + d;
    endtask

    task automatic apply(input int i, input bit lat);
        vec_t        v;
        logic [63:0] d;
        int          npush;
        int          pops0;
        string       tag;
        v     = vt[i];
        tag   = $sformatf("v%0d", i);
        rmode = v.rmode;
        @(posedge clk);
        #1;
        pops0 = n_pops;
        npush = 0;
        if (v.kind == K_SOFEOF) begin
            push(1'b1, 1'b1, rnd());
            npush = 1;
        end else if (v.kind == K_STRAY) begin
            push(1'b0, 1'b1, rnd());
            npush = 1;
        end else begin
            d       = rnd();
            d[29]   = v.b64;
            d[9:0]  = 10'(v.len);
            push(1'b1, 1'b0, d);
            push(1'b0, v.kind == K_ADDR_EOF, v.addr);
            npush = 2;
            if (v.exp_req) exp_req_q.push_back('{v.exp_addr, 10'(v.len), v.b64});
            if (v.kind == K_PKT) begin
                for (int j = 0; j < v.nd; j++) begin
                    d = rnd();
                    push(1'b0, j == v.nd - 1, d);
                    npush++;
                    if (j < v.exp_beats)
                        exp_beat_q.push_back('{d, (j == v.exp_beats - 1) ? v.last_be : 8'hff,
                                               j == v.exp_beats - 1});
                end
            end
        end
        if (lat) begin
            @(negedge clk);
            @(negedge clk);
            chk({tag, "_latency_c1"}, 64'(req_valid), 64'd0);
            @(negedge clk);
            chk({tag, "_latency_c2"}, 64'(req_valid), 64'd1);
        end
        wait_idle(tag);
        exp_pkt += v.d_pkt;
        add_err(v.d_err);
        chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkt));
        chk({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
        chk({tag, "_pops"}, 64'(n_pops - pops0), 64'(npush));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int          cyc;
        int          pops0;

        //           kind       len b64   addr                     nd rm req exp_addr                 bts be     pk er
        vt[0]  = '{K_PKT,      4,  1'b0, 64'h0000_0001_2345_6789, 2,  0, 1, 64'h0000_0000_2345_6788, 2,  8'hff, 1, 0};
        vt[1]  = '{K_PKT,      3,  1'b1, 64'h0000_0001_0000_1000, 2,  0, 1, 64'h0000_0001_0000_1000, 2,  8'h0f, 1, 0};
        vt[2]  = '{K_PKT,      4,  1'b0, 64'h0000_0000_0000_0040, 1,  0, 1, 64'h0000_0000_0000_0040, 1,  8'hff, 0, 1};
        vt[3]  = '{K_PKT,      0,  1'b0, 64'h0000_0000_0000_0000, 4,  0, 0, 64'h0,                   0,  8'hff, 0, 1};
        vt[4]  = '{K_PKT,      8,  1'b0, 64'h0000_0000_8000_0003, 4,  1, 1, 64'h0000_0000_8000_0000, 4,  8'hff, 1, 0};
        vt[5]  = '{K_PKT,      1,  1'b1, 64'hffff_ffff_ffff_fffe, 1,  0, 1, 64'hffff_ffff_ffff_fffc, 1,  8'h0f, 1, 0};
        vt[6]  = '{K_PKT,      2,  1'b0, 64'hdead_beef_0000_1237, 3,  2, 1, 64'h0000_0000_0000_1234, 1,  8'hff, 1, 0};
        vt[7]  = '{K_PKT,      32, 1'b1, 64'h0000_00ab_cdef_0010, 16, 2, 1, 64'h0000_00ab_cdef_0010, 16, 8'hff, 1, 0};
        vt[8]  = '{K_PKT,      33, 1'b0, 64'h0000_0000_0000_0100, 2,  0, 0, 64'h0,                   0,  8'hff, 0, 1};
        vt[9]  = '{K_SOFEOF,   0,  1'b0, 64'h0,                   0,  0, 0, 64'h0,                   0,  8'hff, 0, 1};
        vt[10] = '{K_STRAY,    0,  1'b0, 64'h0,                   0,  0, 0, 64'h0,                   0,  8'hff, 0, 0};
        vt[11] = '{K_ADDR_EOF, 4,  1'b0, 64'h0000_0000_0000_0200, 0,  0, 0, 64'h0,                   0,  8'hff, 0, 1};
        vt[12] = '{K_PKT,      5,  1'b0, 64'h0000_0000_0000_0100, 3,  1, 1, 64'h0000_0000_0000_0100, 3,  8'h0f, 1, 0};

        sys_rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_zero("init");
        sys_rst = 1'b0;

        apply(0, 1'b1);
        for (int i = 1; i < NV; i++) apply(i, 1'b0);

        // SOF arriving while beats remain ends the packet and is re-parsed.
        rmode = 0;
        @(posedge clk);
        #1;
        pops0 = n_pops;
        d = rnd(); d[29] = 1'b0; d[9:0] = 10'd4;
        push(1'b1, 1'b0, d);
        push(1'b0, 1'b0, 64'h0000_0000_0000_0200);
        exp_req_q.push_back('{64'h200, 10'd4, 1'b0});
        d = rnd();
        push(1'b0, 1'b0, d);
        exp_beat_q.push_back('{d, 8'hff, 1'b0});
        d = rnd(); d[29] = 1'b0; d[9:0] = 10'd2;
        push(1'b1, 1'b0, d);
        push(1'b0, 1'b0, 64'h0000_0000_0000_0300);
        exp_req_q.push_back('{64'h300, 10'd2, 1'b0});
        d = rnd();
        push(1'b0, 1'b1, d);
        exp_beat_q.push_back('{d, 8'hff, 1'b1});
        wait_idle("sof_in_data");
        exp_pkt += 1;
        add_err(1);
        chk("sof_in_data_pkt", 64'(pkt_count), 64'(exp_pkt));
        chk("sof_in_data_err", 64'(err_count), 64'(exp_err));
        chk("sof_in_data_pops", 64'(n_pops - pops0), 64'd6);

        // Reset in the middle of DATA with entries still queued.
        sb_on = 1'b0;
        @(posedge clk);
        #1;
        d = rnd(); d[29] = 1'b0; d[9:0] = 10'd8;
        push(1'b1, 1'b0, d);
        push(1'b0, 1'b0, 64'h0000_0000_0000_0400);
        for (int j = 0; j < 4; j++) push(1'b0, j == 3, rnd());
        cyc = 0;
        while (!dat_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach_data", 64'(dat_valid), 64'd1);
        chk("rst_leftover", 64'(fq.size() > 0), 64'd1);
        sys_rst = 1'b1;
        @(negedge clk);
        check_reset_zero("midrst");
        sys_rst = 1'b0;
        wait_idle("rst_flush");
        exp_pkt = 0;
        exp_err = 0;
        chk("rst_flush_err", 64'(err_count), 64'd0);
        chk("rst_flush_pkt", 64'(pkt_count), 64'd0);
        sb_on = 1'b1;
        apply(0, 1'b1);

        // Error counter saturation.
        @(posedge clk);
        #1;
        for (int j = 0; j < 260; j++) push(1'b1, 1'b1, rnd());
        wait_idle("sat");
        add_err(260);
        chk("err_saturate", 64'(err_count), 64'(exp_err));
        chk("sat_pkt", 64'(pkt_count), 64'(exp_pkt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
